// File: rtl/gpio_pkg.sv
// Shared types for the GPIO input conditioner: interrupt edge qualifier
// encoding, debounce FSM states and the edge qualification helper.
package gpio_pkg;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    RISE = 2'b01,
    FALL = 2'b10,
    BOTH = 2'b11
  } edge_mode_e;

  typedef enum logic {
    STABLE   = 1'b0,
    SETTLING = 1'b1
  } debounce_state_e;

  // True when an accepted transition matches the selected interrupt qualifier.
  function automatic logic edge_qualified(edge_mode_e mode, logic rise, logic fall);
    return (rise && (mode == RISE || mode == BOTH)) ||
           (fall && (mode == FALL || mode == BOTH));
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// Multi-flop synchronizer bringing an asynchronous pad level into the clk domain.
module gpio_sync #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  // Shift the raw level through the flop chain; the last stage is the safe copy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/gpio_input_conditioner.sv
// GPIO input conditioner: synchronizes the pad level, debounces it, produces
// one-cycle rise/fall pulses, a sticky qualified-edge interrupt and an edge count.
module gpio_input_conditioner
  import gpio_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dataRx,
  input  logic        enable,
  input  logic [1:0]  edgeMode,
  input  logic        irqClr,
  output logic        levelOut,
  output logic        riseEvt,
  output logic        fallEvt,
  output logic        irq,
  output logic [15:0] evtCount
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // Counter value already reached when the next differing sample completes the run.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic            w_sync_q;
  logic            w_differs;
  logic            w_accept;
  logic            w_rise;
  logic            w_fall;
  logic            w_qual;
  edge_mode_e      w_mode;
  debounce_state_e w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  debounce_state_e  r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_rise;
  logic             r_fall;
  logic             r_irq;
  logic [15:0]      r_evt_cnt;

  gpio_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_d     (dataRx),
    .o_q     (w_sync_q)
  );

  assign w_mode    = edge_mode_e'(edgeMode);
  assign w_differs = w_sync_q ^ r_level;

  // Debounce decision: count consecutive samples that differ from the held level.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    if (!enable || !w_differs) begin
      // Disabled or back at the held level: any partial run is abandoned.
      w_state_nxt = STABLE;
      w_cnt_nxt   = '0;
    end else if (r_state == STABLE) begin
      if (DEBOUNCE_CYCLES == 1) begin
        w_accept    = 1'b1;
        w_state_nxt = STABLE;
        w_cnt_nxt   = '0;
      end else begin
        w_state_nxt = SETTLING;
        w_cnt_nxt   = CNT_W'(1);
      end
    end else if (r_cnt == CNT_LAST) begin
      w_accept    = 1'b1;
      w_state_nxt = STABLE;
      w_cnt_nxt   = '0;
    end else begin
      w_cnt_nxt   = r_cnt + CNT_W'(1);
    end
  end

  assign w_rise = w_accept & ~r_level;
  assign w_fall = w_accept &  r_level;
  assign w_qual = edge_qualified(w_mode, w_rise, w_fall);

  // Debounce FSM state and settle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= STABLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Accepted level, edge pulses, sticky interrupt (set beats clear) and edge count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level   <= 1'b0;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
      r_irq     <= 1'b0;
      r_evt_cnt <= '0;
    end else begin
      r_level <= r_level ^ w_accept;
      r_rise  <= w_rise;
      r_fall  <= w_fall;
      if (w_qual) begin
        r_irq     <= 1'b1;
        r_evt_cnt <= r_evt_cnt + 16'd1;
      end else if (irqClr) begin
        r_irq     <= 1'b0;
      end
    end
  end

  assign levelOut = r_level;
  assign riseEvt  = r_rise;
  assign fallEvt  = r_fall;
  assign irq      = r_irq;
  assign evtCount = r_evt_cnt;

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Testbench for gpio_input_conditioner: directed scenarios plus randomized pad
// activity, compared every cycle against a history-based reference model.
module tb_gpio_input_conditioner;

  localparam int SYNC = 2;
  localparam int DC   = 4;

  logic        clk;
  logic        rst_n;
  logic        dataRx;
  logic        enable;
  logic [1:0]  edgeMode;
  logic        irqClr;
  logic        levelOut;
  logic        riseEvt;
  logic        fallEvt;
  logic        irq;
  logic [15:0] evtCount;

  // Second instance with single-sample acceptance, used for the counter wrap.
  logic        rst2_n;
  logic        data2;
  logic        enable2;
  logic [1:0]  mode2;
  logic        clr2;
  logic        level2;
  logic        rise2;
  logic        fall2;
  logic        irq2;
  logic [15:0] cnt2;

  int total;
  int bad;

  // Reference model state
  bit          m_dl[SYNC];
  bit          m_hist[$];
  bit          m_level;
  bit          m_rise;
  bit          m_fall;
  bit          m_irq;
  bit [15:0]   m_cnt;

  gpio_input_conditioner #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .dataRx   (dataRx),
    .enable   (enable),
    .edgeMode (edgeMode),
    .irqClr   (irqClr),
    .levelOut (levelOut),
    .riseEvt  (riseEvt),
    .fallEvt  (fallEvt),
    .irq      (irq),
    .evtCount (evtCount)
  );

  gpio_input_conditioner #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (1)
  ) dut_fast (
    .clk      (clk),
    .rst_n    (rst2_n),
    .dataRx   (data2),
    .enable   (enable2),
    .edgeMode (mode2),
    .irqClr   (clr2),
    .levelOut (level2),
    .riseEvt  (rise2),
    .fallEvt  (fall2),
    .irq      (irq2),
    .evtCount (cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("levelOut", 16'(levelOut), 16'(m_level));
    chk("riseEvt",  16'(riseEvt),  16'(m_rise));
    chk("fallEvt",  16'(fallEvt),  16'(m_fall));
    chk("irq",      16'(irq),      16'(m_irq));
    chk("evtCount", evtCount,      m_cnt);
  endtask

  task automatic model_reset();
    for (int i = 0; i < SYNC; i++) m_dl[i] = 1'b0;
    m_hist.delete();
    m_level = 1'b0;
    m_rise  = 1'b0;
    m_fall  = 1'b0;
    m_irq   = 1'b0;
    m_cnt   = 16'd0;
  endtask

  // One clock: the model predicts from the pre-edge inputs, then the DUT is compared.
  // A new level is accepted once the last DC enabled samples all differ from it.
  task automatic step();
    bit sq;
    bit acc;
    bit qual;
    sq     = m_dl[SYNC-1];
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (!enable) begin
      m_hist.delete();
    end else begin
      m_hist.push_back(sq);
      if (m_hist.size() > DC) void'(m_hist.pop_front());
      acc = (m_hist.size() == DC);
      foreach (m_hist[i]) if (m_hist[i] == m_level) acc = 1'b0;
      if (acc) begin
        m_rise  = !m_level;
        m_fall  = m_level;
        m_level = !m_level;
        m_hist.delete();
      end
    end
    qual = (m_rise && edgeMode[0]) || (m_fall && edgeMode[1]);
    if (qual) begin
      m_irq = 1'b1;
      m_cnt = m_cnt + 16'd1;
    end else if (irqClr) begin
      m_irq = 1'b0;
    end
    for (int i = SYNC - 1; i > 0; i--) m_dl[i] = m_dl[i-1];
    m_dl[0] = dataRx;
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Assert reset between edges, check it acts without a clock, hold it across an edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
  endtask

  initial begin
    bit sv_level;
    bit sv_irq;
    bit [15:0] sv_cnt;
    int len;
    int n;

    total    = 0;
    bad      = 0;
    rst_n    = 1'b1;
    dataRx   = 1'b0;
    enable   = 1'b1;
    edgeMode = 2'b01;
    irqClr   = 1'b0;
    rst2_n   = 1'b1;
    data2    = 1'b0;
    enable2  = 1'b1;
    mode2    = 2'b11;
    clr2     = 1'b0;
    model_reset();

    @(posedge clk);
    #1;
    rst2_n = 1'b0;
    do_reset();

    // Short high pulse is rejected as a glitch
    dataRx = 1'b1;
    steps(3);
    dataRx = 1'b0;
    steps(10);
    chk("glitch_level", 16'(levelOut), 16'd0);
    chk("glitch_count", evtCount, 16'd0);

    // Held rise appears exactly SYNC+DC edges later with a single pulse
    dataRx = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rise_early_level", 16'(levelOut), 16'd0);
    end
    step();
    chk("rise_level", 16'(levelOut), 16'd1);
    chk("rise_pulse", 16'(riseEvt), 16'd1);
    step();
    chk("rise_pulse_end", 16'(riseEvt), 16'd0);
    chk("rise_irq", 16'(irq), 16'd1);
    chk("rise_count", evtCount, 16'd1);
    steps(3);

    // Fall with rise-only qualifier: pulse but no count
    dataRx = 1'b0;
    steps(5);
    step();
    chk("fall_pulse", 16'(fallEvt), 16'd1);
    chk("fall_level", 16'(levelOut), 16'd0);
    step();
    chk("fall_irq", 16'(irq), 16'd1);
    chk("fall_count", evtCount, 16'd1);

    // Clear, then set-wins on a simultaneous clear and qualified edge
    irqClr = 1'b1;
    step();
    irqClr = 1'b0;
    chk("clr_irq", 16'(irq), 16'd0);
    edgeMode = 2'b11;
    dataRx   = 1'b1;
    steps(5);
    irqClr = 1'b1;
    step();
    irqClr = 1'b0;
    chk("setwins_irq", 16'(irq), 16'd1);
    chk("setwins_count", evtCount, 16'd2);
    irqClr = 1'b1;
    step();
    irqClr = 1'b0;
    chk("clr_after_irq", 16'(irq), 16'd0);

    // Reset while settling aborts the run; full latency after release
    dataRx = 1'b0;
    steps(8);
    chk("pre_reset_count", evtCount, 16'd3);
    dataRx = 1'b1;
    steps(4);
    do_reset();
    chk("reset_count", evtCount, 16'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("post_reset_early", 16'(levelOut), 16'd0);
    end
    step();
    chk("post_reset_level", 16'(levelOut), 16'd1);

    // Disabled: pad toggles are ignored, outputs hold
    steps(3);
    sv_level = m_level;
    sv_irq   = m_irq;
    sv_cnt   = m_cnt;
    enable   = 1'b0;
    for (int t = 0; t < 5; t++) begin
      dataRx = ~dataRx;
      steps(6);
    end
    chk("dis_level", 16'(levelOut), 16'(sv_level));
    chk("dis_irq", 16'(irq), 16'(sv_irq));
    chk("dis_count", evtCount, sv_cnt);
    enable = 1'b1;
    steps(8);

    // Qualifier change only affects later edges
    edgeMode = 2'b00;
    dataRx   = ~dataRx;
    steps(8);
    edgeMode = 2'b11;
    steps(2);

    // Randomized pad activity with occasional disable, clears and mode changes
    n = 0;
    while (n < 600) begin
      dataRx = 1'($urandom_range(0, 1));
      len    = int'($urandom_range(1, 7));
      enable = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 7) == 0) edgeMode = 2'($urandom_range(0, 3));
      for (int i = 0; i < len; i++) begin
        irqClr = ($urandom_range(0, 5) == 0);
        step();
        n++;
      end
    end
    irqClr = 1'b0;
    enable = 1'b1;

    // Edge counter wrap on the single-sample instance
    chk("fast_reset_count", cnt2, 16'd0);
    chk("fast_reset_irq", 16'(irq2), 16'd0);
    rst2_n = 1'b1;
    for (int k = 1; k <= 65538; k++) begin
      data2 = k[0];
      @(posedge clk);
      #1;
      if (k == 2) chk("fast_latency_early", 16'(level2), 16'd0);
      if (k == 3) begin
        chk("fast_latency_level", 16'(level2), 16'd1);
        chk("fast_first_count", cnt2, 16'd1);
      end
      if (k == 65537) chk("fast_count_max", cnt2, 16'hFFFF);
    end
    chk("fast_wrap_count", cnt2, 16'h0000);
    chk("fast_wrap_irq", 16'(irq2), 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
